// File: rtl/axi_light_slice_if.sv
// AXI-lite style bundle shared by the slice and its neighbours.
// The master modport drives requests; the slave modport drives responses.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface if_axi_light #(
  parameter int AW = `AXI_ADDR_WIDTH,
  parameter int DW = `AXI_DATA_WIDTH
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_light_slice.sv
// Register slice for the AXI-lite path: one two-entry skid buffer per channel,
// with optional full bypass or response-only registering.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_light_skid #(
  parameter int W    = 32,
  parameter bit PASS = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  generate
    if (PASS) begin : g_pass
      assign in_ready  = out_ready;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_reg
      state_t       state, state_nxt;
      logic [W-1:0] main_q, skid_q;
      logic         rdy_q;
      logic         in_hs, out_hs;
      logic         ld_main, ld_skid, mv_skid;

      assign in_hs     = in_valid & rdy_q;
      assign out_hs    = (state != EMPTY) & out_ready;
      assign in_ready  = rdy_q;
      assign out_valid = (state != EMPTY);
      assign out_data  = main_q;

      always_comb begin
        state_nxt = state;
        ld_main   = 1'b0;
        ld_skid   = 1'b0;
        mv_skid   = 1'b0;
        case (state)
          EMPTY: if (in_hs) begin
            state_nxt = ONE;
            ld_main   = 1'b1;
          end
          ONE: begin
            if (in_hs && out_hs) begin
              ld_main = 1'b1;
            end else if (in_hs) begin
              state_nxt = FULL;
              ld_skid   = 1'b1;
            end else if (out_hs) begin
              state_nxt = EMPTY;
            end
          end
          FULL: if (out_hs) begin
            state_nxt = ONE;
            mv_skid   = 1'b1;
          end
          default: state_nxt = EMPTY;
        endcase
      end

      // Ready is registered from the next state so it never sees out_ready
      // combinationally; the skid entry absorbs the beat accepted meanwhile.
      always_ff @(posedge clk) begin
        if (reset) begin
          state <= EMPTY;
          rdy_q <= 1'b0;
        end else begin
          state <= state_nxt;
          rdy_q <= (state_nxt != FULL);
        end
      end

      always_ff @(posedge clk) begin
        if (ld_main)      main_q <= in_data;
        else if (mv_skid) main_q <= skid_q;
        if (ld_skid)      skid_q <= in_data;
      end
    end
  endgenerate
endmodule

module axi_light_slice #(
  parameter bit BYPASS       = 1'b0,
  parameter bit R_ONLY_SLICE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  if_axi_light.slave   s_axi,
  if_axi_light.master  m_axi
);
  localparam int AW   = `AXI_ADDR_WIDTH;
  localparam int DW   = `AXI_DATA_WIDTH;
  localparam bit FPASS = BYPASS | R_ONLY_SLICE;
  localparam bit RPASS = BYPASS;

  localparam int AW_W = AW + 3;
  localparam int W_W  = DW + DW/8;
  localparam int B_W  = 2;
  localparam int R_W  = DW + 2;

  logic [AW_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  assign aw_in = {s_axi.awprot, s_axi.awaddr};
  assign w_in  = {s_axi.wstrb, s_axi.wdata};
  assign ar_in = {s_axi.arprot, s_axi.araddr};
  assign b_in  = m_axi.bresp;
  assign r_in  = {m_axi.rresp, m_axi.rdata};

  assign {m_axi.awprot, m_axi.awaddr} = aw_out;
  assign {m_axi.wstrb, m_axi.wdata}   = w_out;
  assign {m_axi.arprot, m_axi.araddr} = ar_out;
  assign s_axi.bresp                  = b_out;
  assign {s_axi.rresp, s_axi.rdata}   = r_out;

  axi_light_skid #(.W(AW_W), .PASS(FPASS)) u_aw (
    .clk(clk), .reset(reset),
    .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
    .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out)
  );

  axi_light_skid #(.W(W_W), .PASS(FPASS)) u_w (
    .clk(clk), .reset(reset),
    .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
    .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out)
  );

  axi_light_skid #(.W(AW_W), .PASS(FPASS)) u_ar (
    .clk(clk), .reset(reset),
    .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
    .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out)
  );

  // Response channels run upstream: the slave side of the slice is their output.
  axi_light_skid #(.W(B_W), .PASS(RPASS)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
    .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out)
  );

  axi_light_skid #(.W(R_W), .PASS(RPASS)) u_r (
    .clk(clk), .reset(reset),
    .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
    .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out)
  );
endmodule

// File: tb/tb_axi_light_slice.sv
// Bench for axi_light_slice: directed vectors plus a random phase, with
// per-channel expected queues drained by an output-side monitor.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_axi_light_slice;
  localparam int AW = `AXI_ADDR_WIDTH;
  localparam int DW = `AXI_DATA_WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_axi_light s_if ();
  if_axi_light m_if ();
  if_axi_light sb_if ();
  if_axi_light mb_if ();

  axi_light_slice dut (.clk(clk), .reset(reset), .s_axi(s_if), .m_axi(m_if));
  axi_light_slice #(.BYPASS(1'b1)) dut_byp (.clk(clk), .reset(reset), .s_axi(sb_if), .m_axi(mb_if));

  int checks = 0;
  int errors = 0;

  logic [63:0] q_aw[$], q_w[$], q_ar[$], q_b[$], q_r[$];
  bit          hold   [5];
  logic [63:0] hold_d [5];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int ch, input string nm, input logic v, input logic r, input logic [63:0] d);
    logic [63:0] e;
    bit got;
    e = '0;
    got = 1'b0;
    if (hold[ch]) chk(v === 1'b1 && d === hold_d[ch], {nm, " stable"}, d, hold_d[ch]);
    if (v && r) begin
      case (ch)
        0: if (q_aw.size() > 0) begin e = q_aw.pop_front(); got = 1'b1; end
        1: if (q_w.size()  > 0) begin e = q_w.pop_front();  got = 1'b1; end
        2: if (q_ar.size() > 0) begin e = q_ar.pop_front(); got = 1'b1; end
        3: if (q_b.size()  > 0) begin e = q_b.pop_front();  got = 1'b1; end
        default: if (q_r.size() > 0) begin e = q_r.pop_front(); got = 1'b1; end
      endcase
      if (got) chk(d === e, nm, d, e);
      else     chk(1'b0, {nm, " unexpected beat"}, d, 64'h0);
    end
    hold[ch]   = v && !r;
    hold_d[ch] = d;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) hold[i] = 1'b0;
    end else begin
      mon(0, "aw", m_if.awvalid, m_if.awready, 64'({m_if.awprot, m_if.awaddr}));
      mon(1, "w",  m_if.wvalid,  m_if.wready,  64'({m_if.wstrb, m_if.wdata}));
      mon(2, "ar", m_if.arvalid, m_if.arready, 64'({m_if.arprot, m_if.araddr}));
      mon(3, "b",  s_if.bvalid,  s_if.bready,  64'(s_if.bresp));
      mon(4, "r",  s_if.rvalid,  s_if.rready,  64'({s_if.rresp, s_if.rdata}));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input logic [AW-1:0] addr);
    bit ok;
    ok = 1'b0;
    s_if.arvalid = 1'b1;
    s_if.araddr  = addr;
    s_if.arprot  = 3'd0;
    q_ar.push_back(64'({3'd0, addr}));
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_if.arready) ok = 1'b1;
    end
    chk(ok, "ar accept timeout", 64'(ok), 64'h1);
    @(posedge clk);
    #1;
    s_if.arvalid = 1'b0;
  endtask

  // One random cycle on all five channels; gen=0 only finishes held beats.
  task automatic rnd_step(input bit gen);
    bit a, w, ar, b, r;
    @(negedge clk);
    a  = s_if.awvalid && s_if.awready;
    w  = s_if.wvalid  && s_if.wready;
    ar = s_if.arvalid && s_if.arready;
    b  = m_if.bvalid  && m_if.bready;
    r  = m_if.rvalid  && m_if.rready;
    @(posedge clk);
    #1;
    m_if.awready = gen ? 1'($urandom) : 1'b1;
    m_if.wready  = gen ? 1'($urandom) : 1'b1;
    m_if.arready = gen ? 1'($urandom) : 1'b1;
    s_if.bready  = gen ? 1'($urandom) : 1'b1;
    s_if.rready  = gen ? 1'($urandom) : 1'b1;
    if (!s_if.awvalid || a) begin
      s_if.awvalid = gen && 1'($urandom);
      if (s_if.awvalid) begin
        s_if.awaddr = AW'($urandom); s_if.awprot = 3'($urandom);
        q_aw.push_back(64'({s_if.awprot, s_if.awaddr}));
      end
    end
    if (!s_if.wvalid || w) begin
      s_if.wvalid = gen && 1'($urandom);
      if (s_if.wvalid) begin
        s_if.wdata = DW'($urandom); s_if.wstrb = (DW/8)'($urandom);
        q_w.push_back(64'({s_if.wstrb, s_if.wdata}));
      end
    end
    if (!s_if.arvalid || ar) begin
      s_if.arvalid = gen && 1'($urandom);
      if (s_if.arvalid) begin
        s_if.araddr = AW'($urandom); s_if.arprot = 3'($urandom);
        q_ar.push_back(64'({s_if.arprot, s_if.araddr}));
      end
    end
    if (!m_if.bvalid || b) begin
      m_if.bvalid = gen && 1'($urandom);
      if (m_if.bvalid) begin
        m_if.bresp = 2'($urandom);
        q_b.push_back(64'(m_if.bresp));
      end
    end
    if (!m_if.rvalid || r) begin
      m_if.rvalid = gen && 1'($urandom);
      if (m_if.rvalid) begin
        m_if.rdata = DW'($urandom); m_if.rresp = 2'($urandom);
        q_r.push_back(64'({m_if.rresp, m_if.rdata}));
      end
    end
  endtask

  initial begin
    {s_if.awaddr, s_if.awprot, s_if.awvalid, s_if.wdata, s_if.wstrb, s_if.wvalid,
     s_if.bready, s_if.araddr, s_if.arprot, s_if.arvalid, s_if.rready} = '0;
    {m_if.awready, m_if.wready, m_if.bresp, m_if.bvalid, m_if.arready,
     m_if.rdata, m_if.rresp, m_if.rvalid} = '0;
    {sb_if.awaddr, sb_if.awprot, sb_if.awvalid, sb_if.wdata, sb_if.wstrb, sb_if.wvalid,
     sb_if.bready, sb_if.araddr, sb_if.arprot, sb_if.arvalid, sb_if.rready} = '0;
    {mb_if.awready, mb_if.wready, mb_if.bresp, mb_if.bvalid, mb_if.arready,
     mb_if.rdata, mb_if.rresp, mb_if.rvalid} = '0;

    // Reset state
    reset = 1'b1;
    cyc(3);
    @(negedge clk);
    chk({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid} === 5'b0,
        "reset valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}), 64'h0);
    chk({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} === 5'b0,
        "reset readies", 64'({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1);
    chk({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} === 5'h1f,
        "readies after reset", 64'({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}), 64'h1f);

    // Single write, then two write responses
    {m_if.awready, m_if.wready, m_if.arready, s_if.bready, s_if.rready} = 5'h1f;
    s_if.awvalid = 1'b1; s_if.awaddr = 32'h0000_1000; s_if.awprot = 3'd0;
    s_if.wvalid  = 1'b1; s_if.wdata  = 32'hDEAD_BEEF; s_if.wstrb  = 4'hF;
    q_aw.push_back(64'h0000_1000);
    q_w.push_back(64'hF_DEAD_BEEF);
    @(negedge clk);
    chk(m_if.awvalid === 1'b0, "aw before capture", 64'(m_if.awvalid), 64'h0);
    cyc(1);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    chk(m_if.awvalid === 1'b1 && m_if.wvalid === 1'b1, "aw/w latency 1",
        64'({m_if.awvalid, m_if.wvalid}), 64'h3);
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    q_b.push_back(64'h0);
    cyc(1);
    chk(s_if.bvalid === 1'b1, "b latency 1", 64'(s_if.bvalid), 64'h1);
    chk(m_if.awvalid === 1'b0, "aw drained", 64'(m_if.awvalid), 64'h0);
    m_if.bresp = 2'b10;
    q_b.push_back(64'h2);
    cyc(1);
    m_if.bvalid = 1'b0;
    cyc(2);

    // AR back-pressure: two beats captured, then in-order release with no gap
    m_if.arready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_ar(AW'(i * 4));
      end
      begin
        cyc(5);
        @(negedge clk);
        chk(s_if.arready === 1'b0, "ar ready drops when full", 64'(s_if.arready), 64'h0);
        @(posedge clk); #1;
        m_if.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk(m_if.arvalid === 1'b1, "ar no gap", 64'(m_if.arvalid), 64'h1);
        end
        @(negedge clk);
        chk(m_if.arvalid === 1'b0, "ar drained", 64'(m_if.arvalid), 64'h0);
      end
    join

    // R streaming: 64 beats back to back
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          m_if.rvalid = 1'b1; m_if.rdata = DW'($urandom); m_if.rresp = 2'(i);
          q_r.push_back(64'({m_if.rresp, m_if.rdata}));
          @(posedge clk); #1;
        end
        m_if.rvalid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
          @(negedge clk);
          chk(s_if.rvalid === 1'b1 && m_if.rready === 1'b1, "r stream continuous",
              64'({s_if.rvalid, m_if.rready}), 64'h3);
        end
        @(negedge clk);
        chk(s_if.rvalid === 1'b0, "r stream end", 64'(s_if.rvalid), 64'h0);
      end
    join

    // Reset while the AW buffer is full
    @(posedge clk); #1;
    m_if.awready = 1'b0;
    s_if.awvalid = 1'b1; s_if.awaddr = 32'hA0;
    cyc(1);
    s_if.awaddr = 32'hA4;
    cyc(1);
    s_if.awvalid = 1'b0;
    @(negedge clk);
    chk(s_if.awready === 1'b0 && m_if.awvalid === 1'b1, "aw full",
        64'({s_if.awready, m_if.awvalid}), 64'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1);
    chk({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid} === 5'b0,
        "mid reset valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}), 64'h0);
    chk(s_if.awready === 1'b0, "mid reset awready", 64'(s_if.awready), 64'h0);
    reset = 1'b0;
    cyc(1);
    chk({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready} === 5'h1f,
        "readies after mid reset", 64'({s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}), 64'h1f);
    m_if.awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(m_if.awvalid === 1'b0, "no stale aw", 64'(m_if.awvalid), 64'h0);
    end

    // Random valid/ready on all channels, then drain
    for (int i = 0; i < 10000; i++) rnd_step(1'b1);
    for (int i = 0; i < 40; i++) rnd_step(1'b0);
    @(negedge clk);
    chk(q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size() == 0,
        "scoreboard drained", 64'(q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()), 64'h0);

    // Bypass instance: zero latency, direct wiring
    @(posedge clk); #1;
    mb_if.awready = 1'b1;
    sb_if.awvalid = 1'b1; sb_if.awaddr = 32'h0000_1000;
    sb_if.wvalid  = 1'b1; sb_if.wdata  = 32'hDEAD_BEEF; sb_if.wstrb = 4'hF;
    mb_if.bvalid  = 1'b1; mb_if.bresp  = 2'b10;
    #1;
    chk(mb_if.awvalid === 1'b1 && mb_if.awaddr === 32'h0000_1000, "bypass aw",
        64'({mb_if.awvalid, mb_if.awaddr}), 64'h1_0000_1000);
    chk(mb_if.wvalid === 1'b1 && mb_if.wdata === 32'hDEAD_BEEF && mb_if.wstrb === 4'hF, "bypass w",
        64'({mb_if.wvalid, mb_if.wstrb, mb_if.wdata}), 64'h1F_DEAD_BEEF);
    chk(sb_if.awready === 1'b1 && sb_if.wready === 1'b0, "bypass ready",
        64'({sb_if.awready, sb_if.wready}), 64'h2);
    chk(sb_if.bvalid === 1'b1 && sb_if.bresp === 2'b10, "bypass b",
        64'({sb_if.bvalid, sb_if.bresp}), 64'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
